// File: rtl/tetris_input_pkg.sv
// Shared constants for the NES pad front end: button indices, command codes,
// shifter state encoding and the priority encoder used by the command queue.
package tetris_input_pkg;

   localparam int NUM_BUTTONS = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   localparam logic [3:0] CMD_NONE   = 4'd0;
   localparam logic [3:0] CMD_A      = 4'd1;
   localparam logic [3:0] CMD_B      = 4'd2;
   localparam logic [3:0] CMD_SELECT = 4'd3;
   localparam logic [3:0] CMD_START  = 4'd4;
   localparam logic [3:0] CMD_UP     = 4'd5;
   localparam logic [3:0] CMD_DOWN   = 4'd6;
   localparam logic [3:0] CMD_LEFT   = 4'd7;
   localparam logic [3:0] CMD_RIGHT  = 4'd8;

   typedef enum logic [2:0] {
      SH_IDLE  = 3'd0,
      SH_LATCH = 3'd1,
      SH_LOW   = 3'd2,
      SH_HIGH  = 3'd3,
      SH_DONE  = 3'd4
   } shift_state_t;

   // Command code of the lowest set button (A wins); CMD_NONE for an empty mask.
   function automatic logic [3:0] lowest_cmd(input logic [NUM_BUTTONS-1:0] mask);
      logic [3:0] code;
      code = CMD_NONE;
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
         if (mask[i]) code = 4'(i + 1);
      end
      return code;
   endfunction

endpackage

// File: rtl/nes_pad_shifter.sv
// Poll timer and pad serial sequencer: latches the pad once per poll frame,
// clocks out 8 bits and presents the completed active-high word.
module nes_pad_shifter
   import tetris_input_pkg::*;
#(
   parameter int POLL_DIV = 833333,
   parameter int HALF_BIT = 300
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pad_data,
   output logic                   pad_latch,
   output logic                   pad_pulse,
   output logic [NUM_BUTTONS-1:0] word,
   output logic                   frame_done
);

   localparam int CNT_W = $clog2(POLL_DIV);
   localparam int PH_W  = $clog2(2 * HALF_BIT);
   localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_DIV - 1);
   localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2 * HALF_BIT - 1);
   localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_BIT - 1);

   shift_state_t           state;
   shift_state_t           state_nxt;
   logic [CNT_W-1:0]       poll_cnt;
   logic [PH_W-1:0]        ph;
   logic [2:0]             bit_idx;
   logic [NUM_BUTTONS-2:0] sr;
   logic                   poll_wrap;
   logic                   sample;

   assign poll_wrap = (poll_cnt == POLL_LAST);
   assign sample    = (state == SH_LOW) && (ph == HALF_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         SH_IDLE:  if (poll_wrap) state_nxt = SH_LATCH;
         SH_LATCH: if (ph == LATCH_LAST) state_nxt = SH_LOW;
         SH_LOW:   if (ph == HALF_LAST) state_nxt = (bit_idx == 3'd7) ? SH_DONE : SH_HIGH;
         SH_HIGH:  if (ph == HALF_LAST) state_nxt = SH_LOW;
         SH_DONE:  state_nxt = SH_IDLE;
         default:  state_nxt = SH_IDLE;
      endcase
   end

   // Pad strobes are registered from the next state so they never glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= SH_IDLE;
         poll_cnt   <= '0;
         ph         <= '0;
         bit_idx    <= '0;
         pad_latch  <= 1'b0;
         pad_pulse  <= 1'b0;
         frame_done <= 1'b0;
         word       <= '0;
      end else begin
         state      <= state_nxt;
         poll_cnt   <= poll_wrap ? '0 : poll_cnt + 1'b1;
         ph         <= (state_nxt != state) ? '0 : ph + 1'b1;
         pad_latch  <= (state_nxt == SH_LATCH);
         pad_pulse  <= (state_nxt == SH_HIGH);
         frame_done <= (state_nxt == SH_DONE);
         if (state == SH_LATCH && state_nxt == SH_LOW && bit_idx != 3'd0)
            bit_idx <= 3'd0;
         else if (state == SH_IDLE)
            bit_idx <= 3'd0;
         else if (state == SH_LOW && state_nxt == SH_HIGH)
            bit_idx <= bit_idx + 1'b1;
         if (sample && bit_idx == 3'd7)
            word <= {~pad_data, sr};
      end
   end

   // Bits 0..6 collect here; the word is only published once bit 7 arrives.
   always_ff @(posedge clk) begin
      if (sample) sr <= {~pad_data, sr[NUM_BUTTONS-2:1]};
   end

endmodule

// File: rtl/nes_pad_scheduler.sv
// NES pad to game-command bridge: press detection, auto-repeat on Down/Left/Right
// and a one-command-at-a-time valid/ready queue with A as highest priority.
module nes_pad_scheduler
   import tetris_input_pkg::*;
#(
   parameter int POLL_DIV     = 833333,
   parameter int HALF_BIT     = 300,
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pad_data,
   output logic                   pad_latch,
   output logic                   pad_pulse,
   output logic [NUM_BUTTONS-1:0] buttons,
   output logic                   frame_done,
   output logic                   cmd_valid,
   output logic [3:0]             cmd_code,
   input  logic                   cmd_ready
);

   localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
   localparam logic [HOLD_W:0]   DELAY_V  = (HOLD_W + 1)'(REPEAT_DELAY);
   localparam logic [HOLD_W-1:0] RELOAD_V = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);

   logic [NUM_BUTTONS-1:0] prev;
   logic [NUM_BUTTONS-1:0] pending;
   logic [NUM_BUTTONS-1:0] new_press;
   logic [NUM_BUTTONS-1:0] rpt_mask;
   logic [NUM_BUTTONS-1:0] set_mask;
   logic [NUM_BUTTONS-1:0] deq_mask;
   logic [2:0]             rpt_hit;
   logic [3:0]             next_code;
   logic                   load_cmd;

   nes_pad_shifter #(
      .POLL_DIV (POLL_DIV),
      .HALF_BIT (HALF_BIT)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .pad_data   (pad_data),
      .pad_latch  (pad_latch),
      .pad_pulse  (pad_pulse),
      .word       (buttons),
      .frame_done (frame_done)
   );

   assign new_press = buttons & ~prev;

   // Hold counters for Down/Left/Right; they never exceed REPEAT_DELAY-1.
   for (genvar k = 0; k < 3; k++) begin : g_rpt
      localparam int B = BTN_DOWN + k;
      logic [HOLD_W-1:0] cnt;
      logic [HOLD_W:0]   cnt_inc;

      assign cnt_inc    = {1'b0, cnt} + 1'b1;
      assign rpt_hit[k] = frame_done && buttons[B] && !new_press[B] && (cnt_inc == DELAY_V);

      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            cnt <= '0;
         else if (frame_done) begin
            if (!buttons[B] || new_press[B])
               cnt <= '0;
            else if (rpt_hit[k])
               cnt <= RELOAD_V;
            else if (cnt_inc < DELAY_V)
               cnt <= cnt_inc[HOLD_W-1:0];
         end
      end
   end

   assign rpt_mask  = {rpt_hit, 5'b0};
   assign set_mask  = frame_done ? (new_press | rpt_mask) : '0;
   assign next_code = lowest_cmd(pending);
   assign load_cmd  = !cmd_valid && (pending != '0);

   always_comb begin
      deq_mask = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (load_cmd && next_code == 4'(i + 1)) deq_mask[i] = 1'b1;
      end
   end

   // A set arriving with a dequeue of the same bit wins, so no event is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev    <= '0;
         pending <= '0;
      end else begin
         pending <= (pending & ~deq_mask) | set_mask;
         if (frame_done) prev <= buttons;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_valid <= 1'b0;
         cmd_code  <= CMD_NONE;
      end else if (load_cmd) begin
         cmd_valid <= 1'b1;
         cmd_code  <= next_code;
      end else if (cmd_valid && cmd_ready) begin
         cmd_valid <= 1'b0;
         cmd_code  <= CMD_NONE;
      end
   end

endmodule

// File: tb/tb_nes_pad_scheduler.sv
// Bench for nes_pad_scheduler: pad shift-register model plus a command scoreboard.
module tb_nes_pad_scheduler;

   localparam int POLL_DIV     = 2000;
   localparam int HALF_BIT     = 4;
   localparam int REPEAT_DELAY = 3;
   localparam int REPEAT_RATE  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pad_data;
   logic       pad_latch;
   logic       pad_pulse;
   logic [7:0] buttons;
   logic       frame_done;
   logic       cmd_valid;
   logic [3:0] cmd_code;
   logic       cmd_ready = 1'b0;

   logic [7:0] pad_btn = 8'h00;
   logic [7:0] pad_sr = 8'hFF;
   logic       pulse_d = 1'b0;
   logic       unplugged = 1'b0;

   int checks = 0;
   int errors = 0;
   int xfers = 0;
   int cyc = 0;
   logic [3:0] exp_q[$];
   int xfer_cyc[$];
   bit mon_en = 1'b1;
   bit prev_hold = 1'b0;
   bit prev_xfer = 1'b0;
   logic [3:0] prev_code = 4'd0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   nes_pad_scheduler #(
      .POLL_DIV     (POLL_DIV),
      .HALF_BIT     (HALF_BIT),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pad_data   (pad_data),
      .pad_latch  (pad_latch),
      .pad_pulse  (pad_pulse),
      .buttons    (buttons),
      .frame_done (frame_done),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code),
      .cmd_ready  (cmd_ready)
   );

   // 4021-style pad: parallel load while latched, shift on pulse rising edge.
   always @(posedge clk) begin
      pulse_d <= pad_pulse;
      if (pad_latch) pad_sr <= ~pad_btn;
      else if (pad_pulse && !pulse_d) pad_sr <= {1'b1, pad_sr[7:1]};
   end
   assign pad_data = unplugged ? 1'b1 : pad_sr[0];

   // Scoreboard side: every transfer pops one expected code.
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_hold) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_code !== prev_code) begin
               errors++;
               $display("FAIL hold_stable valid=%b code=%0d required valid=1 code=%0d", cmd_valid, cmd_code, prev_code);
            end
         end
         if (prev_xfer) begin
            checks++;
            if (cmd_valid !== 1'b0) begin
               errors++;
               $display("FAIL idle_gap valid=%b required 0", cmd_valid);
            end
         end
         if (!cmd_valid) begin
            checks++;
            if (cmd_code !== 4'd0) begin
               errors++;
               $display("FAIL idle_code code=%0d required 0", cmd_code);
            end
         end
         if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_cmd code=%0d required none", cmd_code);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               if (cmd_code !== e) begin
                  errors++;
                  $display("FAIL cmd_code got=%0d required=%0d", cmd_code, e);
               end
            end
            xfers++;
            xfer_cyc.push_back(cyc);
         end
         prev_hold = (cmd_valid === 1'b1) && (cmd_ready !== 1'b1);
         prev_xfer = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
         prev_code = cmd_code;
      end else begin
         prev_hold = 1'b0;
         prev_xfer = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic frames(input int n, input string tag);
      bit ok;
      for (int f = 0; f < n; f++) begin
         ok = 1'b0;
         for (int i = 0; i < POLL_DIV + 200; i++) begin
            @(negedge clk);
            if (frame_done) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s frame_done timeout", tag);
            return;
         end
      end
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && cmd_valid === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic count_to_latch(output int n);
      n = 0;
      while (pad_latch !== 1'b1 && n < 3 * POLL_DIV) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({pad_latch, pad_pulse, buttons, frame_done, cmd_valid, cmd_code} !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h required 0", {pad_latch, pad_pulse, buttons, frame_done, cmd_valid, cmd_code});
      end
      @(negedge clk);
      reset = 1'b0;
      count_to_latch(n);
      checks++;
      if (n != POLL_DIV) begin
         errors++;
         $display("FAIL first_frame_start cycles=%0d required=%0d", n, POLL_DIV);
      end
   endtask

   task automatic test_frame_timing();
      int lat_n = 0, lat_last = -1, pul_n = 0, pul_first = -1, fd_at = -1;
      logic pp = 1'b0;
      logic [7:0] btn_fd = 8'hxx;
      @(negedge clk);
      for (int k = 0; k < 80; k++) begin
         if (pad_latch) begin
            lat_n++;
            lat_last = k;
         end
         if (pad_pulse && !pp) begin
            pul_n++;
            if (pul_first < 0) pul_first = k;
         end
         pp = pad_pulse;
         if (frame_done) begin
            fd_at = k;
            btn_fd = buttons;
         end
         @(negedge clk);
      end
      checks++;
      if (lat_n != 2 * HALF_BIT || lat_last != 2 * HALF_BIT - 1) begin
         errors++;
         $display("FAIL latch_window count=%0d last=%0d required count=8 last=7", lat_n, lat_last);
      end
      checks++;
      if (pul_n != 7 || pul_first != 3 * HALF_BIT) begin
         errors++;
         $display("FAIL pulses count=%0d first=%0d required count=7 first=12", pul_n, pul_first);
      end
      checks++;
      if (fd_at != 17 * HALF_BIT || btn_fd !== 8'h00) begin
         errors++;
         $display("FAIL frame_done at=%0d buttons=%h required at=68 buttons=00", fd_at, btn_fd);
      end
   endtask

   task automatic test_unplugged();
      int base;
      base = xfers;
      pad_btn = 8'hFF;
      unplugged = 1'b1;
      frames(2, "unplugged");
      checks++;
      if (buttons !== 8'h00) begin
         errors++;
         $display("FAIL unplugged_buttons got=%h required 00", buttons);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (xfers != base || cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL unplugged_cmds xfers=%0d valid=%b required 0 0", xfers - base, cmd_valid);
      end
      pad_btn = 8'h00;
      unplugged = 1'b0;
   endtask

   task automatic test_start_no_repeat();
      int base;
      bit ok;
      tick();
      cmd_ready = 1'b1;
      base = xfers;
      pad_btn = 8'h08;
      exp_q.push_back(4'd4);
      frames(5, "start");
      checks++;
      if (buttons !== 8'h08) begin
         errors++;
         $display("FAIL start_buttons got=%h required 08", buttons);
      end
      pad_btn = 8'h00;
      frames(1, "start_rel");
      wait_drain(ok);
      checks++;
      if (!ok || xfers - base != 1) begin
         errors++;
         $display("FAIL start_count xfers=%0d drained=%0d required 1 1", xfers - base, ok);
      end
   endtask

   task automatic test_two_buttons();
      int base;
      bit ok;
      base = xfers;
      xfer_cyc.delete();
      pad_btn = 8'h81;
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd8);
      frames(1, "a_right");
      pad_btn = 8'h00;
      frames(1, "a_right_rel");
      wait_drain(ok);
      checks++;
      if (!ok || xfers - base != 2) begin
         errors++;
         $display("FAIL a_right_count xfers=%0d drained=%0d required 2 1", xfers - base, ok);
      end else begin
         checks++;
         if (xfer_cyc[1] - xfer_cyc[0] != 2) begin
            errors++;
            $display("FAIL a_right_spacing cycles=%0d required 2", xfer_cyc[1] - xfer_cyc[0]);
         end
      end
   endtask

   task automatic test_repeat();
      int base;
      bit ok;
      base = xfers;
      pad_btn = 8'h40;
      repeat (4) exp_q.push_back(4'd7);
      frames(8, "left");
      pad_btn = 8'h00;
      frames(1, "left_rel");
      wait_drain(ok);
      checks++;
      if (!ok || xfers - base != 4) begin
         errors++;
         $display("FAIL left_repeat xfers=%0d drained=%0d required 4 1", xfers - base, ok);
      end
   endtask

   task automatic test_stall();
      int base;
      bit ok;
      tick();
      cmd_ready = 1'b0;
      base = xfers;
      pad_btn = 8'h20;
      exp_q.push_back(4'd6);
      exp_q.push_back(4'd2);
      frames(1, "down");
      pad_btn = 8'h02;
      frames(1, "b1");
      pad_btn = 8'h00;
      frames(1, "rel1");
      pad_btn = 8'h02;
      frames(1, "b2");
      pad_btn = 8'h00;
      frames(1, "rel2");
      @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== 4'd6 || xfers != base) begin
         errors++;
         $display("FAIL stall_hold valid=%b code=%0d xfers=%0d required 1 6 0", cmd_valid, cmd_code, xfers - base);
      end
      tick();
      cmd_ready = 1'b1;
      wait_drain(ok);
      checks++;
      if (!ok || xfers - base != 2) begin
         errors++;
         $display("FAIL stall_count xfers=%0d drained=%0d required 2 1", xfers - base, ok);
      end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      bit ok;
      tick();
      cmd_ready = 1'b0;
      pad_btn = 8'h10;
      frames(1, "up");
      repeat (5) @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== 4'd5 || buttons !== 8'h10) begin
         errors++;
         $display("FAIL pre_reset valid=%b code=%0d buttons=%h required 1 5 10", cmd_valid, cmd_code, buttons);
      end
      ok = 1'b0;
      for (int i = 0; i < POLL_DIV + 100; i++) begin
         @(negedge clk);
         if (pad_pulse === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL pulse_wait timeout pad_pulse=%b required 1", pad_pulse);
      end
      mon_en = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({pad_latch, pad_pulse, cmd_valid, buttons} !== 11'd0) begin
         errors++;
         $display("FAIL async_reset latch=%b pulse=%b valid=%b buttons=%h required all 0", pad_latch, pad_pulse, cmd_valid, buttons);
      end
      exp_q.delete();
      pad_btn = 8'h00;
      cmd_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mon_en = 1'b1;
      count_to_latch(n);
      checks++;
      if (n != POLL_DIV) begin
         errors++;
         $display("FAIL restart_frame cycles=%0d required=%0d", n, POLL_DIV);
      end
      frames(1, "post_reset");
      repeat (10) @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b0 || buttons !== 8'h00) begin
         errors++;
         $display("FAIL post_reset valid=%b buttons=%h required 0 00", cmd_valid, buttons);
      end
   endtask

   initial begin
      test_reset();
      test_frame_timing();
      test_unplugged();
      test_start_no_repeat();
      test_two_buttons();
      test_repeat();
      test_stall();
      test_reset_mid_frame();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expected count=%0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #950000;
      $display("FAIL watchdog time=%0t required finish earlier", $time);
      $fatal(1, "watchdog");
   end

endmodule
